apb_completer_mem: RTL and testbench
====================================

Name: apb_completer_mem

Overview:
- APB4 completer endpoint for one crossbar target port: a small byte-strobed register memory behind the crossbar's completer-side APB interface.
- Inserts a run-time-programmable number of wait states and flags PSLVERR on misaligned or out-of-range accesses.
- Keeps saturating write, read and error transaction counters for testbench scoreboarding.
- Instantiated once per completer ID (0..3) in the NoC testbench and in system integration.

Parameters:
- ADDR_W, 60, PADDR width, equal to {28-bit high, 32-bit low} request address.
- DATA_W, 32, PWDATA/PRDATA width; PSTRB width is DATA_W/8.
- IDX_W, 4, word-index width; MEM_DEPTH = 2**IDX_W words.
- WAIT_W, 4, width of wait_cfg.
- CNT_W, 16, width of the status counters.

Ports:
- pclk, in, 1, APB clock; all state updates on its rising edge.
- preset, in, 1, asynchronous active-high reset.
- psel, in, 1, completer select.
- penable, in, 1, access-phase indicator.
- pwrite, in, 1, 1 = write, 0 = read.
- paddr, in, ADDR_W, byte address.
- pwdata, in, DATA_W, write data.
- pstrb, in, DATA_W/8, write byte enables.
- wait_cfg, in, WAIT_W, wait states inserted per transfer; sampled in the SETUP cycle.
- pready, out, 1, registered transfer-complete.
- prdata, out, DATA_W, registered read data.
- pslverr, out, 1, registered error response.
- wr_cnt, out, CNT_W, completed error-free writes.
- rd_cnt, out, CNT_W, completed error-free reads.
- err_cnt, out, CNT_W, completed transfers with pslverr.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer):
  - FSM goes to IDLE.
  - pready = 0, pslverr = 0, prdata = 0.
  - All memory words = 0; all counters = 0.
  - An interrupted transfer never commits.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on psel=1 and penable=0 (SETUP), latch pwrite, paddr, pwdata, pstrb and wait_cfg into cnt.
    - cnt == 0: go to DONE.
    - Otherwise go to WAIT.
  - WAIT: cnt decrements each cycle; on the cycle cnt reaches 1, go to DONE.
  - DONE: the completion cycle, lasting exactly one cycle, then return to IDLE.
    - pready = 1; pslverr and prdata are valid.
    - The requester samples here with psel=penable=1.
- Latency: pready is asserted in access-phase cycle number wait_cfg+1. wait_cfg = 0 is a zero-wait transfer: SETUP at cycle N, pready at N+1.
- pready, pslverr and prdata are 0 in every state except DONE.
- Error decode: err = (paddr[1:0] != 0) or (paddr[ADDR_W-1:IDX_W+2] != 0). Word index = paddr[IDX_W+1:2].
- Write at DONE, no error: byte b of mem[idx] is replaced by pwdata byte b wherever pstrb[b] = 1. pstrb = 0 is a legal no-op write that still counts in wr_cnt.
- Read at DONE, no error: prdata = mem[idx].
- Any error at DONE:
  - pslverr = 1 and prdata = 0.
  - Memory is unchanged; err_cnt increments.
  - wr_cnt and rd_cnt do not increment.
- Counters saturate at 2**CNT_W-1 and never wrap.
- Protocol abort: psel deasserted while in WAIT or DONE → return to IDLE next cycle, pready = 0, no commit, no counter change.
- penable=1 while in IDLE (no SETUP seen) is ignored.
- Back-to-back transfers: a new SETUP is accepted in the cycle after DONE.
- A SETUP during WAIT is ignored.

Test Plan:
- Reset, then write paddr=0x8, pwdata=0xDEADBEEF, pstrb=0xF, wait_cfg=0 → pready at SETUP+1, pslverr=0, wr_cnt=1. Read 0x8 → prdata=0xDEADBEEF, rd_cnt=1.
- wait_cfg=3, read 0x8 → pready low for 3 access cycles and high on the 4th, prdata=0xDEADBEEF. wait_cfg=15 → pready on the 16th access cycle.
- Write 0x8, pwdata=0x11223344, pstrb=0b0101 → read returns 0xDE22BE44. Write with pstrb=0 → data unchanged, wr_cnt increments.
- Write paddr=0x9 (misaligned), then read paddr=0x1_0000_0040 (out of range) → pslverr=1 and prdata=0 on both, err_cnt=2, memory and wr_cnt/rd_cnt unchanged.
- Write 0x4 with wait_cfg=5, drop psel after 2 access cycles → FSM back in IDLE, read 0x4 returns 0, wr_cnt unchanged. Assert preset mid-WAIT → pready=0 immediately and all counters = 0.
- 65540 back-to-back error-free writes with wait_cfg=0 → wr_cnt saturates at 0xFFFF. Each pready pulse lasts exactly one cycle, and a new SETUP is accepted the cycle after DONE.

Source files
------------

// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a small byte-strobed register memory.
// Inserts programmable wait states, flags PSLVERR on misaligned or
// out-of-range accesses, and keeps saturating transaction counters.
module apb_completer_mem #(
    parameter int ADDR_W = 60,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4,
    parameter int WAIT_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic [WAIT_W-1:0]   wait_cfg,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int MEM_DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_W-1:0]   mem_d [MEM_DEPTH];
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    // Misaligned or beyond the implemented word range.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
    endfunction

    // Next-state, request latching, commit at DONE and registered response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        mem_d     = mem_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    wr_d    = pwrite;
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    cnt_d   = wait_cfg;
                    state_d = (wait_cfg == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // Commit only if the requester is still holding the transfer.
                if (psel) begin
                    if (addr_err(addr_q)) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end else if (wr_q) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (strb_q[b]) begin
                                mem_d[addr_q[IDX_W+1:2]][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Response flops load on entry to DONE; addr_d/wr_d hold the request
        // whether DONE is entered straight from SETUP or from WAIT.
        pready_d  = (state_d == S_DONE);
        pslverr_d = pready_d && addr_err(addr_d);
        prdata_d  = '0;
        if (pready_d && !wr_d && !addr_err(addr_d)) begin
            prdata_d = mem_q[addr_d[IDX_W+1:2]];
        end
    end

    // State, memory and counter registers with asynchronous clear.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;
    assign wr_cnt  = wr_cnt_q;
    assign rd_cnt  = rd_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: directed vector table, hand-written
// abort/reset/idle sequences, randomized transfers against a reference
// model, and counter saturation with narrow counters.
module tb_apb_completer_mem;

    // Narrow counters so saturation is reachable in a few hundred transfers.
    localparam int CW  = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel, penable, pwrite;
    logic [59:0]   paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [3:0]    wait_cfg;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverr;
    logic [CW-1:0] wr_cnt, rd_cnt, err_cnt;

    apb_completer_mem #(
        .ADDR_W(60), .DATA_W(32), .IDX_W(4), .WAIT_W(4), .CNT_W(CW)
    ) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .wait_cfg(wait_cfg), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
    );

    always #5 pclk = ~pclk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        else n_pass++;
    endtask

    // Reference model: word array plus saturating counters.
    logic [31:0] m_mem [16];
    int m_wr, m_rd, m_er;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_wr = 0; m_rd = 0; m_er = 0;
    endtask

    task automatic model_apply(input logic w, input logic [59:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rd, output logic er);
        int idx;
        idx = int'(a[5:2]);
        er = (a % 4 != 0) || (a >= 64);
        rd = '0;
        if (er) begin
            m_er = (m_er < MAXC) ? m_er + 1 : MAXC;
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
            m_wr = (m_wr < MAXC) ? m_wr + 1 : MAXC;
        end else begin
            rd = m_mem[idx];
            m_rd = (m_rd < MAXC) ? m_rd + 1 : MAXC;
        end
    endtask

    // Starts at #1 after a rising edge; ends at #1 after the edge closing DONE
    // with psel released, so a following call issues a back-to-back SETUP.
    task automatic xfer(input logic w, input logic [59:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] wc,
                        output logic [31:0] rd, output logic er, output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a;
        pwdata = d; pstrb = s; wait_cfg = wc;
        @(posedge pclk); #1;
        penable = 1'b1;
        wait_cfg = 4'($urandom);
        lat = 1;
        while (!pready && lat < 40) begin
            @(posedge pclk); #1;
            lat++;
        end
        rd = prdata; er = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", pready, 1'b0);
    endtask

    function automatic logic [59:0] rand_addr();
        logic [59:0] a;
        int unsigned r;
        r = $urandom_range(0, 9);
        a = 60'($urandom_range(0, 15)) << 2;
        if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
        else if (r == 1) a[$urandom_range(6, 59)] = 1'b1;
        return a;
    endfunction

    typedef struct {
        logic        w;
        logic [59:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [3:0]  wc;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_wr;
        int          exp_rdn;
        int          exp_er;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat, bad;

        tbl[0]  = '{1'b1, 60'h8,          32'hDEADBEEF, 4'hF, 4'd0,  32'h0,        1'b0, 1, 0, 0};
        tbl[1]  = '{1'b0, 60'h8,          32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 1'b0, 1, 1, 0};
        tbl[2]  = '{1'b0, 60'h8,          32'h0,        4'h0, 4'd3,  32'hDEADBEEF, 1'b0, 1, 2, 0};
        tbl[3]  = '{1'b0, 60'h8,          32'h0,        4'h0, 4'd15, 32'hDEADBEEF, 1'b0, 1, 3, 0};
        tbl[4]  = '{1'b1, 60'h8,          32'h11223344, 4'h5, 4'd0,  32'h0,        1'b0, 2, 3, 0};
        tbl[5]  = '{1'b0, 60'h8,          32'h0,        4'h0, 4'd0,  32'hDE22BE44, 1'b0, 2, 4, 0};
        tbl[6]  = '{1'b1, 60'h8,          32'hFFFFFFFF, 4'h0, 4'd2,  32'h0,        1'b0, 3, 4, 0};
        tbl[7]  = '{1'b0, 60'h8,          32'h0,        4'h0, 4'd1,  32'hDE22BE44, 1'b0, 3, 5, 0};
        tbl[8]  = '{1'b1, 60'h9,          32'hFFFFFFFF, 4'hF, 4'd0,  32'h0,        1'b1, 3, 5, 1};
        tbl[9]  = '{1'b0, 60'h1_0000_0040, 32'h0,       4'h0, 4'd2,  32'h0,        1'b1, 3, 5, 2};
        tbl[10] = '{1'b0, 60'h8,          32'h0,        4'h0, 4'd0,  32'hDE22BE44, 1'b0, 3, 6, 2};

        // Reset state.
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", pready, 1'b0);
        chk("rst_pslverr", pslverr, 1'b0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_cnts", {wr_cnt, rd_cnt, err_cnt}, '0);
        preset = 1'b0;
        @(posedge pclk); #1;

        // Directed vectors.
        foreach (tbl[i]) begin
            xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].wc, rd, er, lat);
            model_apply(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, mrd, mer);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].wc + 1);
            chk($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), er, tbl[i].exp_err);
            chk($sformatf("vec%0d_wr_cnt", i), wr_cnt, tbl[i].exp_wr);
            chk($sformatf("vec%0d_rd_cnt", i), rd_cnt, tbl[i].exp_rdn);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, tbl[i].exp_er);
        end

        // penable high in IDLE without a SETUP must be ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 60'h8; pstrb = 4'hF; wait_cfg = '0;
        repeat (3) begin
            @(posedge pclk); #1;
            chk("idle_penable_pready", pready, 1'b0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("idle_penable_cnts", {wr_cnt, rd_cnt, err_cnt}, {CW'(m_wr), CW'(m_rd), CW'(m_er)});

        // Abort in WAIT: write 0x4, wait 5, psel dropped after 2 access cycles.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 60'h4;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; wait_cfg = 4'd5;
        @(posedge pclk); #1; penable = 1'b1;
        chk("abort_acc1_pready", pready, 1'b0);
        @(posedge pclk); #1;
        chk("abort_acc2_pready", pready, 1'b0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("abort_idle_pready", pready, 1'b0);
        xfer(1'b0, 60'h4, '0, '0, 4'd0, rd, er, lat);
        model_apply(1'b0, 60'h4, '0, '0, mrd, mer);
        chk("abort_rd_latency", lat, 1);
        chk("abort_rd_data", rd, 32'h0);
        chk("abort_wr_cnt", wr_cnt, CW'(m_wr));

        // Abort in DONE: psel dropped during the completion cycle.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 60'hC;
        pwdata = 32'h55AA55AA; pstrb = 4'hF; wait_cfg = 4'd0;
        @(posedge pclk); #1; penable = 1'b1;
        chk("done_abort_pready", pready, 1'b1);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("done_abort_wr_cnt", wr_cnt, CW'(m_wr));
        xfer(1'b0, 60'hC, '0, '0, 4'd0, rd, er, lat);
        model_apply(1'b0, 60'hC, '0, '0, mrd, mer);
        chk("done_abort_rd_data", rd, mrd);

        // Randomized transfers against the model.
        for (int n = 0; n < 150; n++) begin
            logic w;
            logic [59:0] a;
            logic [31:0] d;
            logic [3:0] s, wc;
            w = 1'($urandom); a = rand_addr(); d = $urandom;
            s = 4'($urandom); wc = 4'($urandom_range(0, 4));
            xfer(w, a, d, s, wc, rd, er, lat);
            model_apply(w, a, d, s, mrd, mer);
            chk("rand_latency", lat, wc + 1);
            chk("rand_prdata", rd, mrd);
            chk("rand_pslverr", er, mer);
            chk("rand_cnts", {wr_cnt, rd_cnt, err_cnt}, {CW'(m_wr), CW'(m_rd), CW'(m_er)});
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end

        // Asynchronous reset in the middle of WAIT.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 60'h8; wait_cfg = 4'd5;
        @(posedge pclk); #1; penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("midrst_pready", pready, 1'b0);
        chk("midrst_cnts", {wr_cnt, rd_cnt, err_cnt}, '0);
        psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 60'h8, '0, '0, 4'd0, rd, er, lat);
        model_apply(1'b0, 60'h8, '0, '0, mrd, mer);
        chk("midrst_mem_cleared", rd, 32'h0);
        chk("midrst_rd_cnt", rd_cnt, 1);

        // Back-to-back writes past counter saturation.
        bad = 0;
        for (int n = 0; n < MAXC + 5; n++) begin
            logic [59:0] a;
            logic [31:0] d;
            a = 60'($urandom_range(0, 15)) << 2;
            d = $urandom;
            xfer(1'b1, a, d, 4'hF, 4'd0, rd, er, lat);
            model_apply(1'b1, a, d, 4'hF, mrd, mer);
            if (lat != 1 || er !== 1'b0) bad++;
        end
        chk("b2b_latency", bad, 0);
        chk("sat_wr_cnt", wr_cnt, MAXC);
        chk("sat_rd_cnt", rd_cnt, 1);
        xfer(1'b0, 60'h3C, '0, '0, 4'd0, rd, er, lat);
        model_apply(1'b0, 60'h3C, '0, '0, mrd, mer);
        chk("sat_rd_back", rd, mrd);
        chk("sat_wr_cnt_hold", wr_cnt, MAXC);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
